// File: rtl/mem_tile_reader.sv
// mem_tile_reader: reads a width x height tile from a one-cycle-latency memory
// read port in raster order and emits it as a valid/ready pixel stream, using
// a two-entry skid FIFO to absorb read latency and downstream backpressure.
module mem_tile_reader #(
    parameter int unsigned ADDR_W = 21,
    parameter int unsigned DATA_W = 18,
    parameter int unsigned DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic [ADDR_W-1:0] stride,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_frame_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              row_last;
        logic              frame_last;
    } entry_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  w_q, w_d;
    logic [DIM_W-1:0]  h_q, h_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic              inflight_q, inflight_d;
    logic              infl_rl_q, infl_rl_d;
    logic              infl_fl_q, infl_fl_d;
    entry_t            fifo_q [2];
    entry_t            fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pop_c;
    logic              push_c;
    logic [2:0]        level_c;
    logic              issue_c;
    logic              col_last_c;
    logic              frame_last_c;

    // Handshake, occupancy look-ahead and read-issue decision
    assign pop_c        = (count_q != 2'd0) && out_ready;
    assign push_c       = inflight_q;
    assign level_c      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_c};
    assign issue_c      = (state_q == S_RUN) && (level_c < 3'd2);
    assign col_last_c   = (col_q == w_q - DIM_W'(1));
    assign frame_last_c = col_last_c && (row_q == h_q - DIM_W'(1));

    // Address of the pixel at the current tile cursor
    assign mem_addr = row_base_q + ADDR_W'(col_q);

    assign out_valid      = (count_q != 2'd0);
    assign out_data       = fifo_q[rd_ptr_q].data;
    assign out_last       = fifo_q[rd_ptr_q].row_last;
    assign out_frame_last = fifo_q[rd_ptr_q].frame_last;
    assign busy           = busy_q;
    assign done           = done_q;

    // In-flight tracking and FIFO push/pop bookkeeping
    always_comb begin
        inflight_d = issue_c;
        infl_rl_d  = issue_c && col_last_c;
        infl_fl_d  = issue_c && frame_last_c;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, push_c} - {1'b0, pop_c};
        if (push_c) begin
            fifo_d[wr_ptr_q].data       = mem_data;
            fifo_d[wr_ptr_q].row_last   = infl_rl_q;
            fifo_d[wr_ptr_q].frame_last = infl_fl_q;
            wr_ptr_d                    = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // Tile sequencing FSM: next state, cursor advance and status outputs
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        col_d      = col_q;
        row_d      = row_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d        = width;
                    h_d        = height;
                    stride_d   = stride;
                    row_base_d = base_addr;
                    col_d      = '0;
                    row_d      = '0;
                    if ((width == '0) || (height == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue_c) begin
                    if (col_last_c) begin
                        col_d      = '0;
                        row_d      = row_q + DIM_W'(1);
                        row_base_d = row_base_q + stride_q;
                        if (frame_last_c) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last beat is accepted so done follows it directly
                if (!inflight_q && (count_d == 2'd0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            infl_rl_q  <= 1'b0;
            infl_fl_q  <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= inflight_d;
            infl_rl_q  <= infl_rl_d;
            infl_fl_q  <= infl_fl_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_tile_reader.sv
// Directed bench for mem_tile_reader with a behavioural memory (mem[i] = i*10).
module tb_mem_tile_reader;

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 18;
    localparam int unsigned DIM_W  = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ADDR_W-1:0] stride;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              out_frame_last;

    mem_tile_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .width          (width),
        .height         (height),
        .stride         (stride),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .out_frame_last (out_frame_last)
    );

    always #5 clk = ~clk;

    // One-cycle-latency memory, contents mem[i] = i*10 truncated to the word width
    always @(posedge clk) begin
        mem_data <= DATA_W'(32'(mem_addr) * 32'd10);
    end

    int n_tests = 0;
    int n_fail  = 0;

    int beat_data[$];
    int beat_last[$];
    int beat_fl[$];
    int exp_q[$];
    int first_v, last_b, done_cyc, done_cnt, busy_cnt, stab_viol;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a tile, stream it with the given ready duty, optionally re-start mid-tile or abort by reset
    task automatic run_tile(input logic [ADDR_W-1:0] b, input logic [DIM_W-1:0] w,
                            input logic [DIM_W-1:0] h, input logic [ADDR_W-1:0] s,
                            input int pct, input int restart_at, input int abort_after);
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        beat_data.delete();
        beat_last.delete();
        beat_fl.delete();
        first_v = -1; last_b = -1; done_cyc = -1;
        done_cnt = 0; busy_cnt = 0; stab_viol = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                base_addr = b; width = w; height = h; stride = s; start = 1'b1;
            end else if (cyc == restart_at) begin
                base_addr = 21'd500; width = 10'd7; height = 10'd2; stride = 21'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            out_ready = ($urandom_range(99) < pct);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_stall && (!out_valid || out_data != prev_data)) stab_viol++;
            if (out_valid) begin
                if (first_v < 0) first_v = cyc;
                if (out_ready) begin
                    beat_data.push_back(int'(out_data));
                    beat_last.push_back(int'(out_last));
                    beat_fl.push_back(int'(out_frame_last));
                    last_b = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (abort_after > 0 && beat_data.size() == abort_after) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(out_valid), 64'd0);
                check("abort_data", 64'(out_data), 64'd0);
                check("abort_last", 64'(out_last), 64'd0);
                check("abort_flast", 64'(out_frame_last), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_done", 64'(done), 64'd0);
                check("abort_addr", 64'(mem_addr), 64'd0);
                break;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
    endtask

    // Compare collected beats with exp_q, row length w
    task automatic check_stream(input string tag, input int w);
        int n;
        check({tag, "_count"}, 64'(beat_data.size()), 64'(exp_q.size()));
        n = (beat_data.size() < exp_q.size()) ? beat_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(beat_data[i]), 64'(exp_q[i]));
            check($sformatf("%s_last%0d", tag, i), 64'(beat_last[i]), 64'(((i + 1) % w) == 0));
            check($sformatf("%s_flast%0d", tag, i), 64'(beat_fl[i]), 64'(i == exp_q.size() - 1));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; width = '0; height = '0; stride = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_flast", 64'(out_frame_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full-rate tile
        run_tile(21'd100, 10'd4, 10'd3, 21'd16, 100, -1, 0);
        exp_q = '{1000, 1010, 1020, 1030, 1160, 1170, 1180, 1190, 1320, 1330, 1340, 1350};
        check_stream("t1", 4);
        check("t1_first_valid", 64'(first_v), 64'd3);
        check("t1_last_beat", 64'(last_b), 64'd14);
        check("t1_done_cyc", 64'(done_cyc), 64'd15);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_busy_cnt", 64'(busy_cnt), 64'd15);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // 2: same tile with ~40% ready
        run_tile(21'd100, 10'd4, 10'd3, 21'd16, 40, -1, 0);
        check_stream("t2", 4);
        check("t2_stable", 64'(stab_viol), 64'd0);
        check("t2_done_after_last", 64'(done_cyc - last_b), 64'd1);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);

        // 3: address wrap at the top of the address space
        run_tile(21'h1FFFFE, 10'd4, 10'd1, 21'd0, 100, -1, 0);
        exp_q = '{262124, 262134, 0, 10};
        check_stream("t3", 4);

        // 4: empty tile
        run_tile(21'd100, 10'd0, 10'd5, 21'd16, 100, -1, 0);
        check("t4_beats", 64'(beat_data.size()), 64'd0);
        check("t4_done_cyc", 64'(done_cyc), 64'd1);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_busy_cnt", 64'(busy_cnt), 64'd1);

        // 5: ignored mid-tile start, then reset abort after beat 5, then a fresh tile
        run_tile(21'd100, 10'd4, 10'd3, 21'd16, 100, 4, 5);
        exp_q = '{1000, 1010, 1020, 1030, 1160};
        check("t5_beats", 64'(beat_data.size()), 64'd5);
        for (int i = 0; i < 5 && i < beat_data.size(); i++)
            check($sformatf("t5_data%0d", i), 64'(beat_data[i]), 64'(exp_q[i]));
        check("t5_no_done", 64'(done_cnt), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy || out_valid) done_cnt++;
        end
        check("t5_quiet_in_reset", 64'(done_cnt), 64'd0);
        rst_n = 1'b1;
        run_tile(21'd200, 10'd2, 10'd2, 21'd10, 100, -1, 0);
        exp_q = '{2000, 2010, 2100, 2110};
        check_stream("t5b", 2);
        check("t5b_first_valid", 64'(first_v), 64'd3);
        check("t5b_done_cnt", 64'(done_cnt), 64'd1);

        // 6: single-column tile with negative stride
        run_tile(21'd50, 10'd1, 10'd3, 21'h1FFFFF, 100, -1, 0);
        exp_q = '{500, 490, 480};
        check_stream("t6", 1);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
